// File: rtl/fifo_uart_tx.sv
// UART transmitter fed by an upstream synchronous FIFO: fetches one word per frame
// and serialises start, WIDTH data bits LSB first, optional even parity, and stop.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [WIDTH-1:0]   r_shift;
  logic               r_parity;
  logic               r_armed;
  logic               r_tx;
  logic               r_rd_en;
  logic               r_busy;
  logic               r_done;

  logic               w_bit_end;
  logic               w_last_bit;

  assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == IDX_W'(WIDTH - 1));

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // branch reads the pre-edge values and the outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_armed   <= 1'b0;
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // r_armed holds off the first fetch until the second edge after reset release.
      r_armed <= 1'b1;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_armed && enable_i && !fifo_empty_i) begin
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_shift  <= fifo_rdata_i;
          r_parity <= ^fifo_rdata_i;
          r_baud   <= '0;
          r_tx     <= 1'b0;
          r_state  <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_last_bit) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= {1'b0, r_shift[WIDTH-1:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = r_rd_en;
  assign tx_o         = r_tx;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule
